// File: rtl/mul_share_sched.sv
// Round-robin scheduler sharing one pipelined multiplier among NUM_REQ requesters.
// Optional macro MUL_SHARE_ZERO_BYPASS_EN: zero operands bypass the multiplier with a zero result.
module mul_share_sched #(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH_A   = 16,
    parameter int WIDTH_B   = 16,
    parameter int WIDTH_MUL = 32,
    parameter int MUL_LAT   = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*WIDTH_A-1:0]     req_a,
    input  logic [NUM_REQ*WIDTH_B-1:0]     req_b,
    output logic [NUM_REQ-1:0]             rsp_valid,
    input  logic [NUM_REQ-1:0]             rsp_ready,
    output logic [NUM_REQ*WIDTH_MUL-1:0]   rsp_data,
    output logic [WIDTH_A-1:0]             mul_a,
    output logic [WIDTH_B-1:0]             mul_b,
    output logic                           mul_in_valid,
    input  logic [WIDTH_MUL-1:0]           mul_out,
    output logic                           busy
);

    localparam int PW = $clog2(NUM_REQ);

    logic [PW-1:0]                 rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0]            pending_q, pending_d;
    logic [WIDTH_A-1:0]            mul_a_q, mul_a_d;
    logic [WIDTH_B-1:0]            mul_b_q, mul_b_d;
    logic                          mul_in_valid_q, mul_in_valid_d;
    logic [MUL_LAT:0]              tag_vld_q, tag_vld_d;
    logic [MUL_LAT:0]              tag_zero_q, tag_zero_d;
    logic [PW-1:0]                 tag_idx_q [MUL_LAT+1];
    logic [PW-1:0]                 tag_idx_d [MUL_LAT+1];
    logic [NUM_REQ-1:0]            rsp_valid_q, rsp_valid_d;
    logic [NUM_REQ*WIDTH_MUL-1:0]  rsp_data_q, rsp_data_d;

    logic [NUM_REQ-1:0]            eligible;
    logic [NUM_REQ-1:0]            consume;
    logic [PW:0]                   cand;
    logic                          grant_vld;
    logic [PW-1:0]                 grant_idx;
    logic [WIDTH_A-1:0]            grant_a;
    logic [WIDTH_B-1:0]            grant_b;
    logic                          grant_zero;
    logic                          ret_vld;
    logic                          ret_zero;
    logic [PW-1:0]                 ret_idx;

    assign eligible = req_valid & ~pending_q;
    assign consume  = rsp_valid_q & rsp_ready;

    // First eligible requester at or after rr_ptr, wrapping; nothing is granted while in reset.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr_q} + (PW+1)'(k);
            if (cand >= (PW+1)'(NUM_REQ)) begin
                cand = cand - (PW+1)'(NUM_REQ);
            end
            if (!grant_vld && eligible[cand[PW-1:0]]) begin
                grant_vld = 1'b1;
                grant_idx = cand[PW-1:0];
            end
        end
        if (!rst_n) begin
            grant_vld = 1'b0;
        end
    end

    always_comb begin
        req_ready = '0;
        if (grant_vld) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign grant_a = req_a[grant_idx*WIDTH_A +: WIDTH_A];
    assign grant_b = req_b[grant_idx*WIDTH_B +: WIDTH_B];

`ifdef MUL_SHARE_ZERO_BYPASS_EN
    assign grant_zero = (grant_a == '0) || (grant_b == '0);
`else
    assign grant_zero = 1'b0;
`endif

    // Stage 0 lines up with mul_in_valid; stage MUL_LAT lines up with mul_out.
    assign ret_vld  = tag_vld_q[MUL_LAT];
    assign ret_zero = tag_zero_q[MUL_LAT];
    assign ret_idx  = tag_idx_q[MUL_LAT];

    always_comb begin
        rr_ptr_d       = rr_ptr_q;
        mul_in_valid_d = grant_vld & ~grant_zero;
        mul_a_d        = mul_a_q;
        mul_b_d        = mul_b_q;
        tag_vld_d      = tag_vld_q;
        tag_zero_d     = tag_zero_q;
        tag_idx_d      = tag_idx_q;
        pending_d      = pending_q & ~consume;
        rsp_valid_d    = rsp_valid_q & ~consume;
        rsp_data_d     = rsp_data_q;

        if (grant_vld) begin
            rr_ptr_d = (grant_idx == PW'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
            pending_d[grant_idx] = 1'b1;
        end
        if (mul_in_valid_d) begin
            mul_a_d = grant_a;
            mul_b_d = grant_b;
        end

        tag_vld_d[0]  = grant_vld;
        tag_zero_d[0] = grant_zero;
        tag_idx_d[0]  = grant_idx;
        for (int k = 1; k <= MUL_LAT; k++) begin
            tag_vld_d[k]  = tag_vld_q[k-1];
            tag_zero_d[k] = tag_zero_q[k-1];
            tag_idx_d[k]  = tag_idx_q[k-1];
        end

        // A returning tag always finds its buffer empty: one outstanding op per requester.
        if (ret_vld) begin
            rsp_valid_d[ret_idx] = 1'b1;
            rsp_data_d[ret_idx*WIDTH_MUL +: WIDTH_MUL] = ret_zero ? '0 : mul_out;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q       <= '0;
            pending_q      <= '0;
            mul_a_q        <= '0;
            mul_b_q        <= '0;
            mul_in_valid_q <= 1'b0;
            tag_vld_q      <= '0;
            tag_zero_q     <= '0;
            for (int k = 0; k <= MUL_LAT; k++) begin
                tag_idx_q[k] <= '0;
            end
            rsp_valid_q    <= '0;
            rsp_data_q     <= '0;
        end else begin
            rr_ptr_q       <= rr_ptr_d;
            pending_q      <= pending_d;
            mul_a_q        <= mul_a_d;
            mul_b_q        <= mul_b_d;
            mul_in_valid_q <= mul_in_valid_d;
            tag_vld_q      <= tag_vld_d;
            tag_zero_q     <= tag_zero_d;
            tag_idx_q      <= tag_idx_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_data_q     <= rsp_data_d;
        end
    end

    assign mul_a        = mul_a_q;
    assign mul_b        = mul_b_q;
    assign mul_in_valid = mul_in_valid_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_data     = rsp_data_q;
    assign busy         = |pending_q;

endmodule

// File: tb/tb_mul_share_sched.sv
// Self-checking bench for mul_share_sched: requester-level reference model plus directed literal checks.
module tb_mul_share_sched;

    localparam int N   = 4;
    localparam int WA  = 16;
    localparam int WB  = 16;
    localparam int WM  = 32;
    localparam int LAT = 2;
`ifdef MUL_SHARE_ZERO_BYPASS_EN
    localparam bit ZB = 1'b1;
`else
    localparam bit ZB = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*WA-1:0]   req_a;
    logic [N*WB-1:0]   req_b;
    logic [N-1:0]      rsp_valid;
    logic [N-1:0]      rsp_ready;
    logic [N*WM-1:0]   rsp_data;
    logic [WA-1:0]     mul_a;
    logic [WB-1:0]     mul_b;
    logic              mul_in_valid;
    logic [WM-1:0]     mul_out;
    logic              busy;

    always #5 clk = ~clk;

    mul_share_sched #(
        .NUM_REQ(N), .WIDTH_A(WA), .WIDTH_B(WB), .WIDTH_MUL(WM), .MUL_LAT(LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .mul_a(mul_a), .mul_b(mul_b), .mul_in_valid(mul_in_valid),
        .mul_out(mul_out), .busy(busy)
    );

    // Exact pipelined multiplier; garbage on idle slots so misaligned sampling shows up.
    logic [WM-1:0] pipe [LAT];
    always @(posedge clk) begin
        pipe[0] <= mul_in_valid ? (WM'(mul_a) * WM'(mul_b)) : $urandom;
        for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end
    assign mul_out = pipe[LAT-1];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Requester-level model
    int            m_ptr;
    bit            m_pend [N];
    bit            m_has  [N];
    int            m_due  [N];
    logic [WM-1:0] m_prod [N];
    logic [WM-1:0] m_last [N];
    logic [WA-1:0] m_ma;
    logic [WB-1:0] m_mb;
    bit            m_miv;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s (cycle %0d): actual=0x%0h required=0x%0h", nm, cyc, act, exp_v);
        end
    endtask

    task automatic model_compare();
        int g;
        bit ev;
        logic [N-1:0] exp_rdy;
        logic [WA-1:0] ga;
        logic [WB-1:0] gb;
        bit zero;
        bit any_pend;
        if (!rst_n) begin
            chk("rst_req_ready", req_ready, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_rsp_data", {63'd0, |rsp_data}, 0);
            chk("rst_mul_a", mul_a, 0);
            chk("rst_mul_b", mul_b, 0);
            chk("rst_mul_in_valid", mul_in_valid, 0);
            chk("rst_busy", busy, 0);
            m_ptr = 0; m_ma = '0; m_mb = '0; m_miv = 1'b0;
            for (int i = 0; i < N; i++) begin
                m_pend[i] = 1'b0; m_has[i] = 1'b0; m_due[i] = 0;
                m_prod[i] = '0; m_last[i] = '0;
            end
            return;
        end
        g = -1;
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_ptr + k) % N;
            if (g < 0 && req_valid[i] && !m_pend[i]) g = i;
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("req_ready", req_ready, exp_rdy);
        chk("mul_in_valid", mul_in_valid, m_miv);
        chk("mul_a", mul_a, m_ma);
        chk("mul_b", mul_b, m_mb);
        any_pend = 1'b0;
        for (int i = 0; i < N; i++) any_pend |= m_pend[i];
        chk("busy", busy, any_pend);
        for (int i = 0; i < N; i++) begin
            ev = m_has[i] && (cyc >= m_due[i]);
            chk($sformatf("rsp_valid[%0d]", i), rsp_valid[i], ev);
            chk($sformatf("rsp_data[%0d]", i), rsp_data[i*WM +: WM], ev ? m_prod[i] : m_last[i]);
            if (ev && rsp_ready[i]) begin
                m_has[i]  = 1'b0;
                m_pend[i] = 1'b0;
                m_last[i] = m_prod[i];
            end
        end
        m_miv = 1'b0;
        if (g >= 0) begin
            ga   = req_a[g*WA +: WA];
            gb   = req_b[g*WB +: WB];
            zero = ZB && (ga == 0 || gb == 0);
            m_pend[g] = 1'b1;
            m_has[g]  = 1'b1;
            m_due[g]  = cyc + LAT + 2;
            m_prod[g] = zero ? '0 : WM'(ga) * WM'(gb);
            if (!zero) begin
                m_miv = 1'b1; m_ma = ga; m_mb = gb;
            end
            m_ptr = (g + 1) % N;
        end
    endtask

    task automatic sample();
        @(negedge clk);
        model_compare();
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sample();
        adv();
        rst_n = 1'b1;
    endtask

    task automatic rand_ops();
        for (int i = 0; i < N; i++) begin
            req_a[i*WA +: WA] = ($urandom_range(7) == 0) ? '0 : WA'($urandom);
            req_b[i*WB +: WB] = ($urandom_range(7) == 0) ? '0 : WB'($urandom);
        end
    endtask

    logic [N-1:0] exp_rr [10];
    int           others;

    initial begin
        exp_rr = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000,
                   4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};
        rst_n = 1'b0; req_valid = '0; rsp_ready = '0; req_a = '0; req_b = '0;
        repeat (3) @(posedge clk);
        #1 req_valid = '1;
        #1 chk("reset_gates_ready", req_ready, 0);
        req_valid = '0;
        sample();
        adv();
        rst_n = 1'b1;

        // Single op: 3*5
        rsp_ready = '1;
        req_valid = 4'b0001; req_a[15:0] = 16'd3; req_b[15:0] = 16'd5;
        sample(); chk("single_grant", req_ready, 4'b0001); adv();
        req_valid = '0;
        sample(); chk("single_miv", mul_in_valid, 1); chk("single_mul_a", mul_a, 3); adv();
        sample(); adv();
        sample(); chk("single_no_early_rsp", rsp_valid, 0); adv();
        sample(); chk("single_rsp_valid", rsp_valid, 4'b0001);
        chk("single_rsp_data", rsp_data[31:0], 15); chk("single_busy_hi", busy, 1); adv();
        sample(); chk("single_busy_fall", busy, 0); chk("single_data_hold", rsp_data[31:0], 15); adv();

        // Round-robin fairness, all requesters continuously valid
        do_reset();
        rsp_ready = '1; req_valid = '1;
        for (int c = 0; c < 10; c++) begin
            rand_ops();
            sample(); chk($sformatf("rr_grant_c%0d", c), req_ready, exp_rr[c]); adv();
        end
        req_valid = '0;
        repeat (6) begin sample(); adv(); end

        // Backpressure on requester 1
        do_reset();
        rsp_ready = 4'b1101; req_valid = 4'b0010;
        req_a[31:16] = 16'd7; req_b[31:16] = 16'd9;
        sample(); chk("bp_grant", req_ready, 4'b0010); adv();
        req_valid = '1;
        others = 0;
        for (int c = 1; c < 14; c++) begin
            sample();
            if ((req_ready & 4'b1101) != 0) others++;
            if (c >= 4) begin
                chk("bp_rsp_valid1", rsp_valid[1], 1);
                chk("bp_rsp_data1", rsp_data[63:32], 63);
                chk("bp_ready1_low", req_ready[1], 0);
            end
            adv();
        end
        chk("bp_others_issue", {63'd0, others >= 4}, 1);
        rsp_ready = '1; req_valid = '0;
        repeat (8) begin sample(); adv(); end

        // Wrap-around from rr_ptr=3
        do_reset();
        rsp_ready = '1;
        req_valid = 4'b0010; sample(); chk("wrap_g1", req_ready, 4'b0010); adv();
        req_valid = 4'b0100; sample(); chk("wrap_g2", req_ready, 4'b0100); adv();
        req_valid = 4'b1001; sample(); chk("wrap_g3", req_ready, 4'b1000); adv();
        sample(); chk("wrap_g0", req_ready, 4'b0001); adv();
        req_valid = '0;
        repeat (8) begin sample(); adv(); end

        // Reset mid-flight after three grants
        do_reset();
        rsp_ready = '1; req_valid = '1;
        for (int c = 0; c < 3; c++) begin rand_ops(); sample(); adv(); end
        rst_n = 1'b0;
        #1;
        chk("midrst_req_ready", req_ready, 0);
        chk("midrst_miv", mul_in_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_mul_a", mul_a, 0);
        sample(); adv();
        rst_n = 1'b1; req_valid = '0;
        for (int c = 0; c < 8; c++) begin
            sample(); chk("midrst_no_rsp", rsp_valid, 0); adv();
        end

        // Zero operand
        do_reset();
        rsp_ready = '1; req_valid = 4'b0100;
        req_a[47:32] = 16'd0; req_b[47:32] = 16'd7;
        sample(); chk("zero_grant", req_ready, 4'b0100); adv();
        req_valid = '0;
        sample(); chk("zero_miv", mul_in_valid, !ZB); adv();
        sample(); adv();
        sample(); adv();
        sample(); chk("zero_rsp_valid", rsp_valid, 4'b0100); chk("zero_rsp_data", rsp_data[95:64], 0); adv();

        // Randomized traffic
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            req_valid = N'($urandom);
            for (int i = 0; i < N; i++) rsp_ready[i] = ($urandom_range(3) != 0);
            rand_ops();
            sample(); adv();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
